// File: rtl/midi_uart_rx.sv
// MIDI serial receiver: 8x-oversampled UART deserializer with a valid/ready byte output,
// framing/overrun pulses and an Active Sensing (0xFE) dead-link monitor driven by keep_alive.
module midi_uart_rx #(
    parameter int OVERSAMPLE    = 8,
    parameter int SENSE_TIMEOUT = 2
) (
    input  logic       i_midi_system_clock,
    input  logic       i_midi_rst,
    input  logic       i_midi_in,
    input  logic       i_keep_alive,
    input  logic       i_rx_ready,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_sense_active,
    output logic       o_sense_timeout
);

    localparam logic [2:0] PH_LAST  = 3'(OVERSAMPLE - 1);
    localparam logic [2:0] PH_VOTE  = 3'd5;
    localparam logic [3:0] KA_LIMIT = 4'(SENSE_TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} state_t;

    state_t      r_state, w_state_next;
    logic        r_sync1, r_s_in, r_s_prev;
    logic [2:0]  r_phase, r_bit_idx;
    logic        r_smp3, r_smp4;
    logic [7:0]  r_shift;
    logic [7:0]  r_rx_data;
    logic        r_rx_valid, r_frame_err, r_overrun;
    logic        r_sense_active, r_sense_timeout;
    logic [3:0]  r_ka_cnt;
    logic [3:0]  w_ka_inc;
    logic        w_maj, w_vote, w_good, w_bad, w_load, w_drop;

    // State register
    always_ff @(posedge i_midi_system_clock or posedge i_midi_rst) begin
        if (i_midi_rst) r_state <= S_IDLE;
        else            r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:      if (r_s_prev && !r_s_in) w_state_next = S_START;
            S_START:     if (w_vote && w_maj) w_state_next = S_IDLE;
                         else if (r_phase == PH_LAST) w_state_next = S_DATA;
            S_DATA:      if (r_phase == PH_LAST && r_bit_idx == 3'd7) w_state_next = S_STOP;
            S_STOP:      if (w_vote) w_state_next = w_maj ? S_IDLE : S_WAIT_HIGH;
            S_WAIT_HIGH: if (r_s_in) w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
    end

    // Output/decode logic
    always_comb begin
        w_maj    = (r_smp3 & r_smp4) | (r_smp3 & r_s_in) | (r_smp4 & r_s_in);
        w_vote   = (r_phase == PH_VOTE);
        w_good   = (r_state == S_STOP) && w_vote && w_maj;
        w_bad    = (r_state == S_STOP) && w_vote && !w_maj;
        w_load   = w_good && (!r_rx_valid || i_rx_ready);
        w_drop   = w_good && r_rx_valid && !i_rx_ready;
        w_ka_inc = r_ka_cnt + 4'd1;
    end

    always_ff @(posedge i_midi_system_clock or posedge i_midi_rst) begin
        if (i_midi_rst) begin
            r_sync1         <= 1'b1;
            r_s_in          <= 1'b1;
            r_s_prev        <= 1'b1;
            r_phase         <= 3'd0;
            r_bit_idx       <= 3'd0;
            r_smp3          <= 1'b1;
            r_smp4          <= 1'b1;
            r_shift         <= 8'h00;
            r_rx_data       <= 8'h00;
            r_rx_valid      <= 1'b0;
            r_frame_err     <= 1'b0;
            r_overrun       <= 1'b0;
            r_sense_active  <= 1'b0;
            r_sense_timeout <= 1'b0;
            r_ka_cnt        <= 4'd0;
        end else begin
            r_sync1  <= i_midi_in;
            r_s_in   <= r_sync1;
            r_s_prev <= r_s_in;

            // Phase restarts at 0 whenever the receiver is parked waiting for an edge
            if (w_state_next == S_IDLE || w_state_next == S_WAIT_HIGH) r_phase <= 3'd0;
            else                                                       r_phase <= r_phase + 3'd1;

            if (r_phase == 3'd3) r_smp3 <= r_s_in;
            if (r_phase == 3'd4) r_smp4 <= r_s_in;

            if (r_state == S_DATA && w_vote) r_shift <= {w_maj, r_shift[7:1]};

            if (r_state == S_START)                            r_bit_idx <= 3'd0;
            else if (r_state == S_DATA && r_phase == PH_LAST)  r_bit_idx <= r_bit_idx + 3'd1;

            if (w_load) r_rx_data <= r_shift;
            r_rx_valid  <= w_load || (r_rx_valid && !i_rx_ready);
            r_frame_err <= w_bad;
            r_overrun   <= w_drop;

            // A good frame always wins over a coincident keep_alive pulse
            if (w_good) begin
                r_ka_cnt        <= 4'd0;
                r_sense_timeout <= 1'b0;
                if (r_shift == 8'hFE) r_sense_active <= 1'b1;
            end else if (i_keep_alive && r_sense_active) begin
                if (w_ka_inc >= KA_LIMIT) begin
                    r_ka_cnt        <= KA_LIMIT;
                    r_sense_timeout <= 1'b1;
                    r_sense_active  <= 1'b0;
                end else begin
                    r_ka_cnt <= w_ka_inc;
                end
            end
        end
    end

    assign o_rx_data       = r_rx_data;
    assign o_rx_valid      = r_rx_valid;
    assign o_frame_err     = r_frame_err;
    assign o_overrun       = r_overrun;
    assign o_sense_active  = r_sense_active;
    assign o_sense_timeout = r_sense_timeout;

endmodule

// File: tb/tb_midi_uart_rx.sv
// Scoreboard bench for midi_uart_rx: stimulus pushes expected bytes, a negedge monitor
// pops them on each accepted handshake; flag pulses are counted and checked per scenario.
module tb_midi_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       midi_in = 1'b1;
    logic       keep_alive = 1'b0;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, sense_active, sense_timeout;

    int checks = 0;
    int errors = 0;
    int n_valid_cycles = 0;
    int n_ferr = 0;
    int n_ovr = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    midi_uart_rx #(.OVERSAMPLE(8), .SENSE_TIMEOUT(2)) dut (
        .i_midi_system_clock(clk),
        .i_midi_rst         (rst),
        .i_midi_in          (midi_in),
        .i_keep_alive       (keep_alive),
        .i_rx_ready         (rx_ready),
        .o_rx_data          (rx_data),
        .o_rx_valid         (rx_valid),
        .o_frame_err        (frame_err),
        .o_overrun          (overrun),
        .o_sense_active     (sense_active),
        .o_sense_timeout    (sense_timeout)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        midi_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        midi_in = v;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    // Monitor: one line per accepted byte, compared against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (rx_valid)  n_valid_cycles++;
                if (frame_err) n_ferr++;
                if (overrun)   n_ovr++;
                if (rx_valid && rx_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", int'(rx_data), -1);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        $display("rx byte 0x%02h (expected 0x%02h)", rx_data, e);
                        check("rx_data", int'(rx_data), int'(e));
                    end
                end
            end
        end
    end

    initial begin
        int v0, f0, o0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rx_data", int'(rx_data), 0);
        check("rst_rx_valid", int'(rx_valid), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_sense_active", int'(sense_active), 0);
        check("rst_sense_timeout", int'(sense_timeout), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(10);

        // 1: simple byte, ready high
        v0 = n_valid_cycles; f0 = n_ferr; o0 = n_ovr;
        exp_q.push_back(8'h90);
        send_frame(8'h90, 1'b1);
        idle(16);
        check("t1_valid_cycles", n_valid_cycles - v0, 1);
        check("t1_frame_err", n_ferr - f0, 0);
        check("t1_overrun", n_ovr - o0, 0);

        // 2: two-cycle glitch is a false start, then a clean byte
        f0 = n_ferr;
        midi_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle(20);
        exp_q.push_back(8'h45);
        send_frame(8'h45, 1'b1);
        idle(16);
        check("t2_frame_err", n_ferr - f0, 0);

        // 3: bad stop bit, line held low, recovery
        f0 = n_ferr;
        send_frame(8'h3C, 1'b0);
        midi_in = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        idle(10);
        exp_q.push_back(8'h7F);
        send_frame(8'h7F, 1'b1);
        idle(16);
        check("t3_frame_err", n_ferr - f0, 1);

        // 4: overrun with consumer stalled
        rx_ready = 1'b0;
        o0 = n_ovr;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(16);
        check("t4_rx_data_held", int'(rx_data), 8'h11);
        check("t4_rx_valid_held", int'(rx_valid), 1);
        check("t4_overrun", n_ovr - o0, 1);
        rx_ready = 1'b1;
        @(posedge clk); #1;
        check("t4_valid_drop", int'(rx_valid), 0);
        idle(4);

        // 5: active sensing timeout and recovery
        exp_q.push_back(8'hFE);
        send_frame(8'hFE, 1'b1);
        idle(16);
        check("t5_active_set", int'(sense_active), 1);
        check("t5_timeout_low", int'(sense_timeout), 0);
        keep_alive = 1'b1; @(posedge clk); #1; keep_alive = 1'b0;
        idle(5);
        check("t5_ka1_timeout", int'(sense_timeout), 0);
        check("t5_ka1_active", int'(sense_active), 1);
        keep_alive = 1'b1; @(posedge clk); #1; keep_alive = 1'b0;
        idle(5);
        check("t5_ka2_timeout", int'(sense_timeout), 1);
        check("t5_ka2_active", int'(sense_active), 0);
        exp_q.push_back(8'hF8);
        send_frame(8'hF8, 1'b1);
        idle(16);
        check("t5_timeout_cleared", int'(sense_timeout), 0);

        // 6: reset during bit 4 of 0xA5
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'hA5 >> i));
        midi_in = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_rx_data", int'(rx_data), 0);
        check("t6_rst_rx_valid", int'(rx_valid), 0);
        check("t6_rst_sense", int'({sense_active, sense_timeout, frame_err, overrun}), 0);
        midi_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(10);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        idle(16);

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so the run always terminates
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "time limit");
    end

endmodule
